// File: rtl/queue_rr_arbiter_if.sv
// queue_rr_arbiter_if
// Bundles the requester-side and queue-side signals of queue_rr_arbiter.
//   req_want  : per-requester intent to transfer
//   req_en    : per-requester transfer strobe (only meaningful while req_rdy is high)
//   req_rdy   : per-requester ready, one-hot or zero
//   req_msg   : flattened messages, requester i at [i*data_width +: data_width]
//   q_enq_en  : enqueue strobe to the downstream queue
//   q_enq_rdy : downstream queue not full
//   q_enq_msg : enqueue message
//   grant_id  : index of the current grantee
// Modports: slave = arbiter side, master = requesters/queue side.
interface queue_rr_arbiter_if #(
    parameter int num_reqs   = 4,
    parameter int data_width = 32
);
    localparam int IDW = (num_reqs > 1) ? $clog2(num_reqs) : 1;

    logic [num_reqs-1:0]            req_want;
    logic [num_reqs-1:0]            req_en;
    logic [num_reqs-1:0]            req_rdy;
    logic [num_reqs*data_width-1:0] req_msg;
    logic                           q_enq_en;
    logic                           q_enq_rdy;
    logic [data_width-1:0]          q_enq_msg;
    logic [IDW-1:0]                 grant_id;

    modport slave (
        input  req_want, req_en, req_msg, q_enq_rdy,
        output req_rdy, q_enq_en, q_enq_msg, grant_id
    );

    modport master (
        output req_want, req_en, req_msg, q_enq_rdy,
        input  req_rdy, q_enq_en, q_enq_msg, grant_id
    );
endinterface

// File: rtl/queue_rr_arbiter.sv
// queue_rr_arbiter
// Round-robin arbiter feeding one downstream queue. A requester that wins
// keeps the grant for up to max_burst consecutive transfers (or until it
// drops req_want), then priority moves to the next index.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : queue_rr_arbiter_if.slave (requester handshakes, queue enqueue)
//   xfer_count : [31:0] count of enqueue cycles, only when the macro
//                QUEUE_RR_ARBITER_STATS_EN is defined
module queue_rr_arbiter #(
    parameter int num_reqs   = 4,
    parameter int data_width = 32,
    parameter int max_burst  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef QUEUE_RR_ARBITER_STATS_EN
    output logic [31:0]            xfer_count,
`endif
    queue_rr_arbiter_if.slave      bus
);
    localparam int IDW = (num_reqs > 1) ? $clog2(num_reqs) : 1;
    localparam logic [7:0] MB = 8'(max_burst);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [7:0]     cnt_q, cnt_d;

    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic [num_reqs-1:0] xfer;
    logic           xfer_any;
    int             idx;

    function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] i);
        return (int'(i) == num_reqs - 1) ? '0 : i + 1'b1;
    endfunction

    // Grantee selection
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (state_q == OWNED) begin
            grant_valid = bus.req_want[owner_q];
            grant_idx   = owner_q;
        end else begin
            // Walk downward so the last hit wins: that is the nearest set bit
            // at or above ptr, modulo num_reqs.
            for (int k = num_reqs - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= num_reqs) idx = idx - num_reqs;
                if (bus.req_want[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx[IDW-1:0];
                end
            end
        end
    end

    // Handshake outputs
    always_comb begin
        bus.req_rdy = '0;
        if (grant_valid && bus.q_enq_rdy && !reset)
            bus.req_rdy[grant_idx] = 1'b1;
        xfer          = bus.req_en & bus.req_rdy;
        xfer_any      = |xfer;
        bus.q_enq_en  = xfer_any;
        bus.grant_id  = grant_idx;
        // Only the grantee can be transferring, so mux by grant index.
        bus.q_enq_msg = xfer_any ? bus.req_msg[int'(grant_idx)*data_width +: data_width]
                                 : '0;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (reset) begin
            state_d = IDLE;
            ptr_d   = '0;
            owner_d = '0;
            cnt_d   = '0;
        end else if (bus.q_enq_rdy) begin
            case (state_q)
                IDLE: begin
                    if (xfer_any) begin
                        if (max_burst > 1) begin
                            state_d = OWNED;
                            owner_d = grant_idx;
                            cnt_d   = 8'd1;
                        end else begin
                            ptr_d = nxt(grant_idx);
                        end
                    end
                end
                OWNED: begin
                    if (!bus.req_want[owner_q]) begin
                        // Owner walked away: release with a one-cycle bubble.
                        state_d = IDLE;
                        ptr_d   = nxt(owner_q);
                        cnt_d   = '0;
                    end else if (xfer_any) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == MB) begin
                            state_d = IDLE;
                            ptr_d   = nxt(owner_q);
                            cnt_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        owner_q <= owner_d;
        cnt_q   <= cnt_d;
    end

`ifdef QUEUE_RR_ARBITER_STATS_EN
    logic [31:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (reset)         xfer_count_d = '0;
        else if (xfer_any) xfer_count_d = xfer_count_q + 32'd1;
    end

    always_ff @(posedge clk) xfer_count_q <= xfer_count_d;

    assign xfer_count = xfer_count_q;
`endif
endmodule

// File: doc/queue_rr_arbiter.md
QUEUE_RR_ARBITER -- requirements
Module: queue_rr_arbiter

Interface
REQ-001: Parameter num_reqs SHALL default to 4 and set the number of requesters, legal range 2..16.
REQ-002: Parameter data_width SHALL default to 32 and set the message width.
REQ-003: Parameter max_burst SHALL default to 4 and set the maximum consecutive transfers per grant, legal range 1..255.
REQ-004: clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-005: req_want  input  num_reqs  per-requester intent to transfer.
REQ-006: req_en  input  num_reqs  per-requester transfer strobe, asserted only when the matching req_rdy bit is high.
REQ-007: req_rdy  output  num_reqs  per-requester ready.
REQ-008: req_msg  input  num_reqs*data_width  flattened messages, requester i at bits [i*data_width +: data_width].
REQ-009: q_enq_en  output  1  enqueue strobe to the downstream queue.
REQ-010: q_enq_rdy  input  1  downstream queue not full.
REQ-011: q_enq_msg  output  data_width  enqueue message.
REQ-012: grant_id  output  max(1,$clog2(num_reqs))  index of the current grantee, valid when any req_rdy bit is high.

Function
REQ-013: The block SHALL have two states: IDLE (no owner) and OWNED (owner register, burst count register).
REQ-014: In IDLE the grantee SHALL be the first set req_want bit at or after priority pointer ptr, searching upward modulo num_reqs.
REQ-015: In OWNED the grantee SHALL be the owner, and only when the owner's req_want is high.
REQ-016: req_rdy SHALL be one-hot or zero: only the grantee's bit, and only when q_enq_rdy is high.
REQ-017: A transfer SHALL be req_en[i] & req_rdy[i]; q_enq_en SHALL equal the OR of all transfers, and q_enq_msg SHALL be the transferring requester's message in the same cycle (zero latency, combinational).
REQ-018: On a transfer in IDLE with max_burst>1, the block SHALL enter OWNED with owner=i and count=1.
REQ-019: On a transfer in IDLE with max_burst==1, the block SHALL stay in IDLE and set ptr=(i+1) mod num_reqs.
REQ-020: On a transfer in OWNED, the count SHALL increment; if the new count equals max_burst, the block SHALL return to IDLE with ptr=(owner+1) mod num_reqs.
REQ-021: In OWNED with the owner's req_want low, the block SHALL return to IDLE next cycle with ptr=(owner+1) mod num_reqs; no requester is ready in that cycle.
REQ-022: While q_enq_rdy is low, all req_rdy bits SHALL be low, and state, ptr and count SHALL hold.
REQ-023: A requester with req_want high SHALL be granted within (num_reqs-1)*max_burst + num_reqs cycles in which q_enq_rdy is high (starvation bound).
REQ-024: The pointer SHALL wrap from num_reqs-1 to 0.
REQ-025: If req_en is asserted without req_rdy, it SHALL be ignored.

Reset
REQ-026: While reset is high, next state SHALL be IDLE with ptr=0, count=0 and owner=0, and req_rdy and q_enq_en SHALL be forced to 0.
REQ-027: A reset asserted during OWNED SHALL abandon the burst; the first post-reset grant SHALL follow the pointer=0 search.

Configuration
REQ-028: With macro QUEUE_RR_ARBITER_STATS_EN defined, the block SHALL add output xfer_count[31:0]: a count of q_enq_en cycles, reset to 0, wrapping at 2^32.
REQ-029: Without QUEUE_RR_ARBITER_STATS_EN, the xfer_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030: Reset with all req_want=4'b1111 and q_enq_rdy=1 -> req_rdy=4'b0001 in the first cycle after reset, grant_id=0.
REQ-031: max_burst=4, all wants high, every requester asserts en when ready -> 4 transfers from req0, then 4 from req1, then req2, then req3, with no gap cycles.
REQ-032: Owner req1 drops want after 2 transfers -> one cycle with req_rdy=0, then req2 is granted.
REQ-033: q_enq_rdy=0 for 3 cycles mid-burst at count=2 -> req_rdy=0 and q_enq_en=0 throughout; the burst resumes at count=2 with the same owner.
REQ-034: max_burst=1, wants 4'b1010, ptr=0 -> grants alternate req1, req3, req1; q_enq_msg matches the sender each cycle.
REQ-035: With QUEUE_RR_ARBITER_STATS_EN, after 10 transfers xfer_count=10; a reset mid-run clears it to 0.
